fd_sustain_processor: RTL and testbench

//  Frequency-domain resynthesis stage. Sits after the FFT magnitude/real-part stage in the frequency machine.
//  Per bin, keeps a peak-hold gain with a sustain-controlled decay in a 2**AW-deep gain RAM.

---
 rtl/fd_pkg.sv | 22 ++
 rtl/fd_sustain_processor_gain_tracker.sv | 88 ++++++++
 rtl/ram_sdft.sv | 34 +++
 rtl/shared_oscillator_accumulator.sv | 66 ++++++
 rtl/fd_sustain_processor.sv | 150 +++++++++++++++
 tb/tb_fd_sustain_processor.sv | 193 +++++++++++++++++++
 6 files changed

// File: rtl/fd_pkg.sv
// fd_pkg: shared constants and helpers for the frequency-domain sustain
// processor. Provides the default geometry (AW/NFREQ), the frame counter
// width, the fixed oscillator compression constant and the decay
// coefficient builder.
package fd_pkg;

    localparam int unsigned DW_DEF    = 16;
    localparam int unsigned AW_DEF    = 11;
    localparam int unsigned NFREQ_DEF = 1 << AW_DEF;

    // Frame counter is one bit wider than the bin index.
    localparam int unsigned FCW_DEF   = AW_DEF + 1;

    localparam logic [11:0] COMPRESSION = 12'hFFF;

    // Decay coefficient: sustain in the upper byte, low byte saturated so
    // that sustain=FF gives an almost-unity multiplier.
    function automatic logic [15:0] sustain_coef(input logic [7:0] sustain);
        return {sustain, 8'hFF};
    endfunction

endpackage

// File: rtl/fd_sustain_processor_gain_tracker.sv
// fd_gain_tracker: per-bin peak-hold gain datapath. Stage 1 registers the
// floored bin value and its index; stage 2 applies low-cut, decays the
// stored gain and writes back max(f, decay), f on the first block, or the
// unchanged gain when frozen.
// Ports:
//   clk_i, srst_i   clock, synchronous active-high reset
//   active_i        block active this cycle
//   cnt_i           current bin index (RAM read address)
//   freq_i          bin value
//   floor_i         floor in effect for this block (already sob-selected)
//   low_cut_i       latched low-cut index
//   sustain_i       latched sustain
//   freeze_i        latched freeze
//   act_d_o         active delayed 1
//   idx_d_o         bin index delayed 1
//   gain_rd_o       stored gain of bin idx_d_o
module fd_gain_tracker
    import fd_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 11
) (
    input  logic          clk_i,
    input  logic          srst_i,
    input  logic          active_i,
    input  logic [AW-1:0] cnt_i,
    input  logic [DW-1:0] freq_i,
    input  logic [DW-1:0] floor_i,
    input  logic [AW-1:0] low_cut_i,
    input  logic [7:0]    sustain_i,
    input  logic          freeze_i,
    output logic          act_d_o,
    output logic [AW-1:0] idx_d_o,
    output logic [DW-1:0] gain_rd_o
);

    logic [DW-1:0]    f_q, f_cut, dec, wr_val, gain_rd;
    logic [AW-1:0]    idx_q;
    logic             act_q, first_q;
    logic [DW+15:0]   prod;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            f_q     <= '0;
            idx_q   <= '0;
            act_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            f_q   <= (freq_i < floor_i) ? '0 : freq_i;
            idx_q <= cnt_i;
            act_q <= active_i;
            // Cleared once the last bin of the first complete block is written.
            if (act_q && (idx_q == '1)) begin
                first_q <= 1'b0;
            end
        end
    end

    always_comb begin
        f_cut = (idx_q < low_cut_i) ? '0 : f_q;
        prod  = (DW+16)'(gain_rd) * (DW+16)'(sustain_coef(sustain_i));
        dec   = prod[DW+15:16];
        if (freeze_i) begin
            wr_val = gain_rd;
        end else if (first_q) begin
            wr_val = f_cut;
        end else begin
            wr_val = (f_cut > dec) ? f_cut : dec;
        end
    end

    ram_sdft #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (act_q),
        .waddr_i (idx_q),
        .wdata_i (wr_val),
        .raddr_i (cnt_i),
        .rdata_o (gain_rd)
    );

    assign act_d_o   = act_q;
    assign idx_d_o   = idx_q;
    assign gain_rd_o = gain_rd;

endmodule

// File: rtl/ram_sdft.sv
// ram_sdft: simple dual-port RAM, one write port and one read port,
// registered read (latency 1). No reset: contents persist across srst.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, valid one cycle after raddr_i
module ram_sdft #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 11
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/shared_oscillator_accumulator.sv
// shared_oscillator_accumulator: time-shared additive oscillator bank.
// One bin per cycle is accumulated as +/-gain, the sign taken from the top
// bit of phase = freq_number * frame (FCW bits). On save the block total
// (including the current bin) is scaled by compression/2**(AW+13) and held
// on data_o from the next cycle until the following save.
// Ports:
//   clk_i, srst_i      clock, synchronous active-high reset
//   accumulate_i       add this bin's contribution
//   freq_number_i      bin index
//   freq_gain_i        bin gain
//   save_i             last bin of block: latch scaled total, clear sum
//   compression_i      output scale factor
//   frame_i            frame number
//   data_o             signed 16-bit synthesized value
module shared_oscillator_accumulator #(
    parameter int unsigned DW              = 16,
    parameter int unsigned AW              = 11,
    parameter int unsigned FCW             = AW + 1,
    parameter bit          WEIRD_SOUNDS_EN = 1'b0
) (
    input  logic           clk_i,
    input  logic           srst_i,
    input  logic           accumulate_i,
    input  logic [AW-1:0]  freq_number_i,
    input  logic [DW-1:0]  freq_gain_i,
    input  logic           save_i,
    input  logic [11:0]    compression_i,
    input  logic [FCW-1:0] frame_i,
    output logic [15:0]    data_o
);

    localparam int unsigned SW = AW + DW + 1;
    localparam int unsigned PW = SW + 13;

    logic signed [SW-1:0]     acc_q, sum_d, term;
    logic        [AW+FCW-1:0] phase_full;
    logic        [FCW-1:0]    phase;
    logic                     neg;
    logic signed [PW-1:0]     prod, shifted;
    logic        [15:0]       data_q;

    always_comb begin
        phase_full = (AW+FCW)'(freq_number_i) * (AW+FCW)'(frame_i);
        phase      = phase_full[FCW-1:0];
        neg        = phase[FCW-1] ^ (WEIRD_SOUNDS_EN & phase[0]);
        term       = neg ? -$signed(SW'(freq_gain_i)) : $signed(SW'(freq_gain_i));
        sum_d      = accumulate_i ? acc_q + term : acc_q;
        prod       = PW'(sum_d) * PW'($signed({1'b0, compression_i}));
        shifted    = prod >>> (AW + 13);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            acc_q  <= '0;
            data_q <= '0;
        end else if (save_i) begin
            acc_q  <= '0;
            data_q <= shifted[15:0];
        end else begin
            acc_q  <= sum_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/fd_sustain_processor.sv
// fd_sustain_processor: frequency-domain resynthesis stage. Tracks a
// peak-hold gain per bin with sustain-controlled decay and feeds the gains
// to a shared oscillator, producing one sample per block.
// Ports:
//   clk_i, srst_i    clock, synchronous active-high reset
//   sob_i, eob_i     start / end of block (bin 0 / bin NFREQ-1)
//   freq_i           bin value, one per cycle
//   sustain_i        decay control       (sampled at accepted sob)
//   freeze_i         hold gains          (sampled at accepted sob)
//   floor_i          magnitude floor     (sampled at accepted sob)
//   low_cut_i        low bin cut index   (sampled at accepted sob)
//   sample_o         synthesized sample, held between strobes
//   sample_valid_o   1-cycle strobe, OSC_LAT cycles after the last bin's save
//   alarm_o          1-cycle strobe on protocol error
// OSC_LAT must be >= 2.
module fd_sustain_processor
    import fd_pkg::*;
#(
    parameter int unsigned DW              = DW_DEF,
    parameter int unsigned OW              = 24,
    parameter int unsigned AW              = AW_DEF,
    parameter int unsigned OSC_LAT         = 2,
    parameter bit          WEIRD_SOUNDS_EN = 1'b0
) (
    input  logic          clk_i,
    input  logic          srst_i,
    input  logic          sob_i,
    input  logic          eob_i,
    input  logic [DW-1:0] freq_i,
    input  logic [7:0]    sustain_i,
    input  logic          freeze_i,
    input  logic [DW-1:0] floor_i,
    input  logic [AW-1:0] low_cut_i,
    output logic [OW-1:0] sample_o,
    output logic          sample_valid_o,
    output logic          alarm_o
);

    localparam int unsigned FCW = AW + 1;

    logic [AW-1:0]      cnt_q, cnt_d;
    logic [7:0]         sustain_q;
    logic               freeze_q;
    logic [DW-1:0]      floor_q, floor_eff;
    logic [AW-1:0]      low_cut_q;
    logic               alarm_q, eob_d1_q, eob_d2_q;
    logic [FCW-1:0]     frame_q;
    logic [OSC_LAT-2:0] vpipe_q, vpipe_d;
    logic [OW-1:0]      sample_q;
    logic               sample_valid_q;

    logic               active, sob_acc, last, proto_err;
    logic               act_d, save;
    logic [AW-1:0]      idx_d;
    logic [DW-1:0]      gain_rd;
    logic [15:0]        osc_data;

    always_comb begin
        active    = sob_i | (cnt_q != '0);
        sob_acc   = sob_i & (cnt_q == '0);
        last      = (cnt_q == '1);
        cnt_d     = active ? cnt_q + AW'(1) : cnt_q;
        proto_err = (sob_i & (cnt_q != '0)) | (eob_i & ~last) | (last & ~eob_i);
        // Bin 0 is floored in the sob cycle, before floor_q has been loaded.
        floor_eff = sob_acc ? floor_i : floor_q;
        save      = act_d & (idx_d == '1);
        vpipe_d   = '0;
        vpipe_d[0] = save;
        for (int unsigned i = 1; i < OSC_LAT - 1; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q          <= '0;
            sustain_q      <= '0;
            freeze_q       <= 1'b0;
            floor_q        <= '0;
            low_cut_q      <= '0;
            alarm_q        <= 1'b0;
            eob_d1_q       <= 1'b0;
            eob_d2_q       <= 1'b0;
            frame_q        <= '0;
            vpipe_q        <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            if (sob_acc) begin
                sustain_q <= sustain_i;
                freeze_q  <= freeze_i;
                floor_q   <= floor_i;
                low_cut_q <= low_cut_i;
            end
            alarm_q  <= proto_err;
            eob_d1_q <= eob_i;
            eob_d2_q <= eob_d1_q;
            if (eob_d2_q) begin
                frame_q <= frame_q + FCW'(1);
            end
            vpipe_q        <= vpipe_d;
            // Capture one cycle early so the strobe lands OSC_LAT after save.
            sample_valid_q <= vpipe_q[OSC_LAT-2];
            if (vpipe_q[OSC_LAT-2]) begin
                sample_q <= OW'($signed(osc_data));
            end
        end
    end

    fd_gain_tracker #(
        .DW (DW),
        .AW (AW)
    ) u_tracker (
        .clk_i     (clk_i),
        .srst_i    (srst_i),
        .active_i  (active),
        .cnt_i     (cnt_q),
        .freq_i    (freq_i),
        .floor_i   (floor_eff),
        .low_cut_i (low_cut_q),
        .sustain_i (sustain_q),
        .freeze_i  (freeze_q),
        .act_d_o   (act_d),
        .idx_d_o   (idx_d),
        .gain_rd_o (gain_rd)
    );

    shared_oscillator_accumulator #(
        .DW              (DW),
        .AW              (AW),
        .FCW             (FCW),
        .WEIRD_SOUNDS_EN (WEIRD_SOUNDS_EN)
    ) u_osc (
        .clk_i         (clk_i),
        .srst_i        (srst_i),
        .accumulate_i  (act_d),
        .freq_number_i (idx_d),
        .freq_gain_i   (gain_rd),
        .save_i        (save),
        .compression_i (COMPRESSION),
        .frame_i       (frame_q),
        .data_o        (osc_data)
    );

    assign sample_o       = sample_q;
    assign sample_valid_o = sample_valid_q;
    assign alarm_o        = alarm_q;

endmodule

// File: tb/tb_fd_sustain_processor.sv
// Randomized bench for fd_sustain_processor (AW=4, 16 bins) with a
// behavioural model of the gain RAM, frame count and oscillator sum.
module tb_fd_sustain_processor;

    localparam int DW = 16, OW = 24, AW = 4, OSC_LAT = 2, N = 16;

    logic          clk = 1'b0;
    logic          srst_i = 1'b1, sob_i = 1'b0, eob_i = 1'b0, freeze_i = 1'b0;
    logic [DW-1:0] freq_i = '0, floor_i = '0;
    logic [7:0]    sustain_i = '0;
    logic [AW-1:0] low_cut_i = '0;
    logic [OW-1:0] sample_o;
    logic          sample_valid_o, alarm_o;

    fd_sustain_processor #(.DW(DW), .OW(OW), .AW(AW), .OSC_LAT(OSC_LAT), .WEIRD_SOUNDS_EN(1'b0)) dut (
        .clk_i(clk), .srst_i(srst_i), .sob_i(sob_i), .eob_i(eob_i), .freq_i(freq_i),
        .sustain_i(sustain_i), .freeze_i(freeze_i), .floor_i(floor_i), .low_cut_i(low_cut_i),
        .sample_o(sample_o), .sample_valid_o(sample_valid_o), .alarm_o(alarm_o));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0, nfail = 0;
    int alarms = 0, exp_alarms = 0;

    typedef struct packed { logic [31:0] cyc; logic [OW-1:0] val; logic chk; } smp_t;
    typedef struct packed { logic [31:0] cyc; logic [N-1:0][15:0] g; } ram_t;
    smp_t smpq[$];
    ram_t ramq[$];

    int unsigned mram[N];
    bit first_m = 1'b1, ram_known = 1'b0;
    int frames_m = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (alarm_o) alarms++;
        if (ramq.size() != 0 && ramq[0].cyc == cyc) begin
            ram_t r;
            r = ramq.pop_front();
            for (int k = 0; k < N; k++)
                check_val($sformatf("ram[%0d]", k), 32'(dut.u_tracker.u_ram.mem_q[k]), 32'(r.g[k]));
        end
        if (sample_valid_o) begin
            if (smpq.size() == 0) begin
                check_val("unexpected_strobe", 32'(1), 32'(0));
            end else begin
                smp_t s;
                s = smpq.pop_front();
                check_val("strobe_cycle", 32'(cyc), s.cyc);
                if (s.chk) check_val("sample", 32'(sample_o), 32'(s.val));
            end
        end
    end

    task automatic junk_ctrl();
        sustain_i = 8'($urandom); freeze_i = 1'($urandom);
        floor_i = 16'($urandom); low_cut_i = 4'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            sob_i = 1'b0; eob_i = 1'b0; freq_i = 16'($urandom); junk_ctrl();
        end
    endtask

    // err: 0 clean, 1 sob at bin 7, 2 extra eob at bin 9, 3 missing eob.
    // rst_at: bin at which srst is pulsed (-1 for none).
    task automatic run_block(input int unsigned v[N], input logic [7:0] sus, input bit frz,
                             input int unsigned flr, input int unsigned lc,
                             input int err, input int rst_at, input int gap);
        int unsigned nv[N], f, dec, coef;
        longint sum, sc;
        logic [63:0] scv;
        logic [15:0] d;
        int p15 = 0, ph;
        smp_t s;
        ram_t r;
        coef = sus * 256 + 255;
        sum  = 0;
        for (int k = 0; k < N; k++) begin
            f = (v[k] < flr) ? 0 : v[k];
            if (k < lc) f = 0;
            dec = int'((longint'(mram[k]) * coef) >> 16);
            nv[k] = frz ? mram[k] : first_m ? f : ((f > dec) ? f : dec);
            ph = (k * frames_m) % (2 * N);
            sum += (ph >= N) ? -longint'(mram[k]) : longint'(mram[k]);
        end
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            sob_i  = (k == 0) || (err == 1 && k == 7);
            eob_i  = (k == N - 1 && err != 3) || (err == 2 && k == 9);
            freq_i = v[k][15:0];
            if (k == 0) begin
                sustain_i = sus; freeze_i = frz; floor_i = flr[15:0]; low_cut_i = lc[3:0];
            end else junk_ctrl();
            if (k == N - 1) p15 = cyc;
            if (k == rst_at) begin
                srst_i = 1'b1;
                @(posedge clk); #1;
                srst_i = 1'b0; sob_i = 1'b0; eob_i = 1'b0;
                for (int j = 0; j < rst_at; j++) mram[j] = nv[j];
                first_m = 1'b1; frames_m = 0;
                idle(gap);
                return;
            end
        end
        sc  = (sum * 4095) >>> (AW + 13);
        scv = sc;
        d   = scv[15:0];
        s.cyc = p15 + 1 + OSC_LAT; s.val = OW'($signed(d)); s.chk = ram_known && err != 2;
        smpq.push_back(s);
        for (int k = 0; k < N; k++) begin
            mram[k] = nv[k];
            r.g[k] = nv[k][15:0];
        end
        r.cyc = p15 + 2;
        ramq.push_back(r);
        frames_m = (frames_m + ((err == 2) ? 2 : (err == 3) ? 0 : 1)) % (2 * N);
        first_m = 1'b0; ram_known = 1'b1;
        if (err != 0) exp_alarms++;
        if (gap > 0) begin
            idle(gap);
            check_val("alarm_count", 32'(alarms), 32'(exp_alarms));
        end
    endtask

    function automatic void fill(output int unsigned v[N], input int unsigned val);
        for (int k = 0; k < N; k++) v[k] = val;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned v[N];
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_sample", 32'(sample_o), 32'(0));
        check_val("rst_valid", 32'(sample_valid_o), 32'(0));
        check_val("rst_alarm", 32'(alarm_o), 32'(0));
        @(posedge clk); #1; srst_i = 1'b0;

        // Directed scenarios.
        fill(v, 5000);  run_block(v, 8'h80, 1'b0, 1000, 0, 0, -1, 5);
        fill(v, 8000);  run_block(v, 8'h10, 1'b0, 0, 0, 0, -1, 0);
        fill(v, 0);     run_block(v, 8'h00, 1'b0, 0, 0, 0, -1, 4);
        fill(v, 8000);  run_block(v, 8'h00, 1'b0, 0, 0, 0, -1, 0);
        fill(v, 0);     run_block(v, 8'hFF, 1'b0, 0, 0, 0, -1, 4);
        for (int k = 0; k < N; k++) v[k] = (k % 3 == 0) ? 999 : (k % 3 == 1) ? 1000 : 2000;
        run_block(v, 8'h40, 1'b0, 1000, 3, 0, -1, 4);
        fill(v, 16'hFFFF); run_block(v, 8'h00, 1'b1, 0, 0, 0, -1, 4);
        for (int e = 1; e <= 3; e++) begin
            for (int k = 0; k < N; k++) v[k] = $urandom_range(0, 65535);
            run_block(v, 8'($urandom), 1'b0, $urandom_range(0, 3000), $urandom_range(0, 3), e, -1, 5);
        end
        for (int k = 0; k < N; k++) v[k] = $urandom_range(0, 65535);
        run_block(v, 8'hC0, 1'b0, 0, 0, 0, 10, 4);
        for (int k = 0; k < N; k++) v[k] = $urandom_range(0, 30000);
        run_block(v, 8'hFF, 1'b0, 500, 0, 0, -1, 4);

        // Random blocks, mixing back-to-back and gapped.
        for (int b = 0; b < 40; b++) begin
            int unsigned range;
            range = ($urandom_range(0, 3) == 0) ? 300 : 65535;
            for (int k = 0; k < N; k++) v[k] = $urandom_range(0, range);
            run_block(v, 8'($urandom), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 20000),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 0,
                      0, -1, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(3, 6));
        end
        idle(8);
        check_val("alarm_count_final", 32'(alarms), 32'(exp_alarms));
        check_val("pending_strobes", 32'(smpq.size()), 32'(0));
        check_val("pending_ram_checks", 32'(ramq.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
